// File: rtl/alu_pkg.sv
// alu_pkg: ALUControl encodings and NZCV bit indices shared by the arm_alu slice
package alu_pkg;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/arm_alu_flagreg.sv
// arm_alu_flagreg: FlagWrite-gated NZ/CV status register (clk, reset_n async low, FlagWrite, ALUFlags -> Flags), sticky overflow Q when ALU_STICKY_OVF_EN
module arm_alu_flagreg
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] FlagWrite,
  input  logic [3:0] ALUFlags,
  output logic [3:0] Flags
`ifdef ALU_STICKY_OVF_EN
  ,
  output logic       Q
`endif
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) Flags <= 4'b0000;
    else begin
      if (FlagWrite[1]) Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if (FlagWrite[0]) Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
    end
  end
`ifdef ALU_STICKY_OVF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) Q <= 1'b0;
    else if (FlagWrite[0] && ALUFlags[FLAG_V]) Q <= 1'b1;
  end
`endif
endmodule

// File: rtl/arm_alu.sv
// arm_alu: combinational ADD/SUB/AND/ORR with live NZCV (ALUResult, ALUFlags) plus registered Flags (clk, reset_n, FlagWrite); sticky overflow Q when ALU_STICKY_OVF_EN
module arm_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [1:0]       FlagWrite,
  output logic [WIDTH-1:0] ALUResult,
  output logic [3:0]       ALUFlags,
  output logic [3:0]       Flags
`ifdef ALU_STICKY_OVF_EN
  ,
  output logic             Q
`endif
);
  logic             sub;
  logic             arith;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   sum;
  always_comb begin
    sub   = ALUControl == ALU_SUB;
    arith = ALUControl == ALU_ADD || sub;
    b     = sub ? ~SrcB : SrcB;
    sum   = {1'b0, SrcA} + {1'b0, b} + {{WIDTH{1'b0}}, sub};
    ALUResult = ALUControl == ALU_AND ? SrcA & SrcB :
                ALUControl == ALU_ORR ? SrcA | SrcB : sum[WIDTH-1:0];
    ALUFlags = 4'b0000;
    ALUFlags[FLAG_N] = ALUResult[WIDTH-1];
    ALUFlags[FLAG_Z] = ~|ALUResult;
    ALUFlags[FLAG_C] = arith & sum[WIDTH];
    ALUFlags[FLAG_V] = arith & ~(SrcA[WIDTH-1] ^ SrcB[WIDTH-1] ^ sub) & (SrcA[WIDTH-1] ^ sum[WIDTH-1]);
  end
  arm_alu_flagreg u_flagreg (
    .clk      (clk),
    .reset_n  (reset_n),
    .FlagWrite(FlagWrite),
    .ALUFlags (ALUFlags),
    .Flags    (Flags)
`ifdef ALU_STICKY_OVF_EN
    ,
    .Q        (Q)
`endif
  );
endmodule

// File: tb/tb_arm_alu.sv
// tb_arm_alu: scoreboard bench for arm_alu combinational ops, status register and optional sticky overflow
module tb_arm_alu;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  ALUControl = 2'b00;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic [1:0]  FlagWrite = 2'b00;
  logic [31:0] ALUResult;
  logic [3:0]  ALUFlags;
  logic [3:0]  Flags;
`ifdef ALU_STICKY_OVF_EN
  logic        q;
`endif
  int cmp = 0;
  int bad = 0;
  logic [35:0] comb_q[$];
  logic [3:0]  reg_q[$];
  logic [35:0] e;
  logic [3:0]  ef;
  logic [3:0]  model_flags;

  arm_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ALUControl(ALUControl),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .FlagWrite (FlagWrite),
    .ALUResult (ALUResult),
    .ALUFlags  (ALUFlags),
    .Flags     (Flags)
`ifdef ALU_STICKY_OVF_EN
    ,
    .Q         (q)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    if (op == 2'b00) begin
      r = a + b;
      c = r < a;
      v = (a[31] == b[31]) && (r[31] != a[31]);
    end else if (op == 2'b01) begin
      r = a - b;
      c = a >= b;
      v = (a[31] != b[31]) && (r[31] != a[31]);
    end else if (op == 2'b10) r = a & b;
    else r = a | b;
    return {r, r[31], r == 32'd0, c, v};
  endfunction

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic [3:0] f);
    ALUControl = op;
    SrcA = a;
    SrcB = b;
    comb_q.push_back({r, f});
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    FlagWrite = 2'b11;
    drive(2'b00, 32'h7FFFFFFF, 32'd1, 32'h80000000, 4'b1001);
    reg_q.push_back(4'b0000);
    @(posedge clk);
    #1;
    ef = reg_q.pop_front();
    cmp++;
    if (Flags !== ef) begin
      bad++;
      $display("FAIL reset_flags got=%b want=%b", Flags, ef);
    end
    e = comb_q.pop_front();
    cmp++;
    if ({ALUResult, ALUFlags} !== e) begin
      bad++;
      $display("FAIL comb_during_reset got=%h/%b want=%h/%b", ALUResult, ALUFlags, e[35:4], e[3:0]);
    end
    FlagWrite = 2'b00;
    reset_n = 1'b1;
  endtask

  task automatic test_comb;
    logic [1:0]  op[9] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11, 2'b10};
    logic [31:0] a[9]  = '{32'd1, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'd1, 32'd1, 32'h80000000, 32'd1, 32'd0, 32'hF0};
    logic [31:0] b[9]  = '{32'd0, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd2, 32'd1, 32'd1, 32'd1, 32'h0F};
    logic [31:0] r[9]  = '{32'd1, 32'hFFFFFFFD, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd1, 32'd1, 32'd0};
    logic [3:0]  f[9]  = '{4'b0000, 4'b1010, 4'b1001, 4'b0110, 4'b1000, 4'b0011, 4'b0000, 4'b0000, 4'b0100};
    for (int i = 0; i < 9; i++) begin
      drive(op[i], a[i], b[i], r[i], f[i]);
      #1;
      e = comb_q.pop_front();
      cmp++;
      if ({ALUResult, ALUFlags} !== e) begin
        bad++;
        $display("FAIL comb_vec%0d got=%h/%b want=%h/%b", i, ALUResult, ALUFlags, e[35:4], e[3:0]);
      end
    end
  endtask

  task automatic test_flagreg;
    logic [1:0]  op[4] = '{2'b01, 2'b01, 2'b01, 2'b00};
    logic [31:0] a[4]  = '{32'd1, 32'd1, 32'd1, 32'h7FFFFFFF};
    logic [31:0] b[4]  = '{32'd1, 32'd2, 32'd2, 32'd1};
    logic [1:0]  fw[4] = '{2'b10, 2'b01, 2'b11, 2'b00};
    logic [3:0]  x[4]  = '{4'b0100, 4'b0100, 4'b1000, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      ALUControl = op[i];
      SrcA = a[i];
      SrcB = b[i];
      FlagWrite = fw[i];
      reg_q.push_back(x[i]);
      @(posedge clk);
      #1;
      ef = reg_q.pop_front();
      cmp++;
      if (Flags !== ef) begin
        bad++;
        $display("FAIL flagreg_step%0d got=%b want=%b", i, Flags, ef);
      end
    end
    FlagWrite = 2'b11;
    reset_n = 1'b0;
    #1;
    cmp++;
    if (Flags !== 4'b0000) begin
      bad++;
      $display("FAIL flagreg_async_reset got=%b want=0000", Flags);
    end
    reset_n = 1'b1;
    reg_q.push_back(4'b1001);
    @(posedge clk);
    #1;
    ef = reg_q.pop_front();
    cmp++;
    if (Flags !== ef) begin
      bad++;
      $display("FAIL flagreg_first_after_reset got=%b want=%b", Flags, ef);
    end
    FlagWrite = 2'b00;
  endtask

  task automatic test_back_to_back;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [1:0]  fw;
    logic [35:0] m;
    model_flags = Flags;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = (i % 4 == 0) ? 32'h80000000 : $urandom;
      b = (i % 5 == 0) ? a : $urandom;
      fw = 2'($urandom_range(0, 3));
      m = model(op, a, b);
      drive(op, a, b, m[35:4], m[3:0]);
      FlagWrite = fw;
      if (fw[1]) model_flags[3:2] = m[3:2];
      if (fw[0]) model_flags[1:0] = m[1:0];
      reg_q.push_back(model_flags);
      #1;
      e = comb_q.pop_front();
      cmp++;
      if ({ALUResult, ALUFlags} !== e) begin
        bad++;
        $display("FAIL rand_comb%0d op=%0d a=%h b=%h got=%h/%b want=%h/%b", i, op, a, b, ALUResult, ALUFlags, e[35:4], e[3:0]);
      end
      @(posedge clk);
      #1;
      ef = reg_q.pop_front();
      cmp++;
      if (Flags !== ef) begin
        bad++;
        $display("FAIL rand_flags%0d got=%b want=%b", i, Flags, ef);
      end
    end
    FlagWrite = 2'b00;
  endtask

`ifdef ALU_STICKY_OVF_EN
  task automatic test_sticky;
    logic [1:0]  op[3] = '{2'b00, 2'b00, 2'b01};
    logic [31:0] a[3]  = '{32'h7FFFFFFF, 32'd1, 32'd1};
    logic [31:0] b[3]  = '{32'd1, 32'd0, 32'd1};
    logic [1:0]  fw[3] = '{2'b01, 2'b11, 2'b01};
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ALUControl = op[i];
      SrcA = a[i];
      SrcB = b[i];
      FlagWrite = fw[i];
      @(posedge clk);
      #1;
      cmp++;
      if (q !== 1'b1) begin
        bad++;
        $display("FAIL sticky_step%0d got=%b want=1", i, q);
      end
    end
    FlagWrite = 2'b00;
    reset_n = 1'b0;
    #1;
    cmp++;
    if (q !== 1'b0) begin
      bad++;
      $display("FAIL sticky_reset got=%b want=0", q);
    end
    reset_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_comb();
    test_flagreg();
    test_back_to_back();
`ifdef ALU_STICKY_OVF_EN
    test_sticky();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/arm_alu.md
Name: arm_alu

Overview:
- 32-bit integer ALU for the single-cycle ARM datapath.
- Computes ADD, SUB, AND or ORR of SrcA and SrcB combinationally, with live NZCV condition flags.
- Includes a clocked status (flags) register. It captures the NZ and CV flag groups independently under FlagWrite, for use by the conditional-execution logic.

Parameters:
- WIDTH, 32, operand/result width in bits (must be at least 2).

Ports:
- clk  in  1  rising-edge clock; drives only the status register.
- reset_n  in  1  asynchronous, active-low reset.
- ALUControl  in  2  operation select: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- SrcA  in  WIDTH  operand A.
- SrcB  in  WIDTH  operand B.
- FlagWrite  in  2  bit1 loads N,Z; bit0 loads C,V into the status register.
- ALUResult  out  WIDTH  combinational result.
- ALUFlags  out  4  combinational flags {N,Z,C,V} of the current operation.
- Flags  out  4  registered status {N,Z,C,V}.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (reset_n).
- ALUResult and ALUFlags are purely combinational: zero latency, and independent of clk and reset_n.
- ADD: sum = SrcA + SrcB, computed at WIDTH+1 bits; the carry-out is the MSB.
- SUB: SrcA + ~SrcB + 1, computed at WIDTH+1 bits.
  - C = carry-out, ARM convention: C=1 means no borrow.
  - Example: 1-1 gives C=1; 1-2 gives C=0.
- AND/ORR: bitwise operation; C=0 and V=0.
- N = ALUResult[WIDTH-1]. Z = (ALUResult == 0).
- V is computed for ADD/SUB only: V = ~(A[msb] ^ B'[msb] ^ sub) & (A[msb] ^ sum[msb]), where B' is SrcB and sub=1 for SUB.
  - Equivalently: operands of the same effective sign give a result of the opposite sign.
- Results wrap modulo 2^WIDTH; carry/overflow are reported only through the flags.
- Status register:
  - On reset_n low, Flags = 4'b0000 immediately (asynchronous), held while reset_n is low.
  - On a rising clk with FlagWrite[1]=1, Flags[3:2] <= ALUFlags[3:2].
  - On a rising clk with FlagWrite[0]=1, Flags[1:0] <= ALUFlags[1:0].
  - Both bits set update all four flags in the same cycle. FlagWrite=00 holds the value.
  - A reset asserted mid-cycle wins over any FlagWrite. The first edge after reset release loads normally.
- No X propagation: every ALUControl value is defined.

Optional Feature:
- Macro ALU_STICKY_OVF_EN.
- When defined:
  - Adds output port Q (1 bit), a sticky overflow flag.
  - Q is set on a rising clk when FlagWrite[0]=1 and ALUFlags[0]=1.
  - Q is cleared only by reset_n low (reset value 0).
  - Q never clears on a non-overflowing result.
- When undefined: port Q and its flop are absent; all other behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - ALUControl encodings: ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_ORR=2'b11.
  - Flag bit indices: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One natural sub-module, arm_alu_flagreg: the FlagWrite-gated NZ/CV register with async reset, plus the optional Q bit.
- The arithmetic/logic core stays in arm_alu.

Test Plan:
- ADD, SrcA=1, SrcB=0 -> ALUResult=0x00000001, ALUFlags=0000.
- ADD, SrcA=0xFFFFFFFE, SrcB=0xFFFFFFFF -> ALUResult=0xFFFFFFFD, ALUFlags=1010 (N, C).
  - Also 0x7FFFFFFF+1 -> 0x80000000, ALUFlags=1001 (N, V).
- SUB, 1-1 -> ALUResult=0x00000000, ALUFlags=0110 (Z, C).
  - Also SUB 1-2 -> ALUResult=0xFFFFFFFF, ALUFlags=1000.
  - Also 0x80000000-1 -> 0x7FFFFFFF, ALUFlags=0011.
- AND, 1&1 -> ALUResult=1, ALUFlags=0000.
  - Also ORR 0|1 -> 1.
  - Also AND 0xF0&0x0F -> 0, ALUFlags=0100.
- Status register:
  - Reset -> Flags=0000.
  - SUB 1-1 with FlagWrite=10, one clk -> Flags=0100.
  - Then SUB 1-2 with FlagWrite=01 -> Flags=0100 (C=0, V=0 loaded; NZ held).
  - Then FlagWrite=11 -> Flags=1000.
  - reset_n pulsed low between clk edges -> Flags=0000 immediately.
- With ALU_STICKY_OVF_EN defined:
  - ADD 0x7FFFFFFF+1 with FlagWrite=01, one clk -> Q=1.
  - Subsequent non-overflowing ops -> Q stays 1.
  - reset_n low -> Q=0.
